// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// the operation encodings, the FSM states and small decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    function automatic logic is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of results.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        if (neg) begin
            dout = ~din + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one
// shift-add or restoring subtract-shift step per cycle on magnitudes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hiwe,
    input  logic             lowe,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_r;
    op_e                op_r;
    logic               sa_r;
    logic               sb_r;
    logic               div0_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    op_e                op_s;
    logic               sa_s;
    logic               sb_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   q_fix_s;
    logic [WIDTH-1:0]   r_fix_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    assign op_s = op_e'(op);
    assign sa_s = is_signed_op(op_s) & srca[WIDTH-1];
    assign sb_s = is_signed_op(op_s) & srcb[WIDTH-1];

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
        .neg (sa_s),
        .din (srca),
        .dout(mag_a_s)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
        .neg (sb_s),
        .din (srcb),
        .dout(mag_b_s)
    );

    // Quotient sign is forced positive on divide-by-zero so lo stays all ones.
    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .neg (sa_r ^ sb_r),
        .din (acc_r),
        .dout(prod_fix_s)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_q (
        .neg ((sa_r ^ sb_r) & ~div0_r),
        .din (acc_r[WIDTH-1:0]),
        .dout(q_fix_s)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_r (
        .neg (sa_r),
        .din (acc_r[2*WIDTH-1:WIDTH]),
        .dout(r_fix_s)
    );

    // One iteration step: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        mul_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
        if (acc_r[0]) begin
            mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else begin
            mul_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
        end
        trial_s    = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        diff_s     = trial_s - {1'b0, opnd_r};
        div_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        if (!diff_s[WIDTH]) begin
            div_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
        if (is_div(op_r)) begin
            step_s = div_next_s;
        end else begin
            step_s = mul_next_s;
        end
    end

    // Select the sign-corrected result for hi/lo.
    always_comb begin
        res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_fix_s[WIDTH-1:0];
        if (is_div(op_r)) begin
            res_hi_s = r_fix_s;
            res_lo_s = q_fix_s;
        end else begin
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Control FSM together with the datapath and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            op_r    <= OP_MULT;
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            div0_r  <= 1'b0;
            opnd_r  <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r    <= op_s;
                        sa_r    <= sa_s;
                        sb_r    <= sb_s;
                        div0_r  <= is_div(op_s) && (srcb == {WIDTH{1'b0}});
                        opnd_r  <= is_div(op_s) ? mag_b_s : mag_a_s;
                        acc_r   <= {{WIDTH{1'b0}}, (is_div(op_s) ? mag_a_s : mag_b_s)};
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        if (hiwe) begin
                            hi_r <= wdata;
                        end
                        if (lowe) begin
                            lo_r <= wdata;
                        end
                    end
                end
                ST_RUN: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_r <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    hi_r    <= res_hi_s;
                    lo_r    <= res_lo_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         hiwe;
    logic         lowe;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks;
    int n_fail;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .srca (srca),
        .srcb (srcb),
        .hiwe (hiwe),
        .lowe (lowe),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation from a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input bit inject, input bit wr_with_start);
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        int lat;
        int busy_cnt;
        prev_hi = hi;
        prev_lo = lo;
        start = 1'b1; op = o; srca = a; srcb = b;
        hiwe = wr_with_start; lowe = wr_with_start; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0; hiwe = 1'b0; lowe = 1'b0;
        srca = 32'h5555_AAAA; srcb = 32'h0000_0003; op = 2'b01;
        lat = 100;
        busy_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
            if (k == 9) begin
                check_eq({tag, "_hold_hi"}, hi, prev_hi);
                check_eq({tag, "_hold_lo"}, lo, prev_lo);
            end
            start = 1'b0; hiwe = 1'b0;
            if (inject && k == 5) begin
                start = 1'b1; op = 2'b01; srca = 32'd5; srcb = 32'd5;
            end
            if (inject && k == 7) begin
                hiwe = 1'b1; wdata = 32'h0000_1234;
            end
        end
        start = 1'b0; hiwe = 1'b0;
        check_eq({tag, "_latency"}, lat, 33);
        check_eq({tag, "_busy_cycles"}, busy_cnt, 33);
        check_eq({tag, "_hi"}, hi, exp_hi);
        check_eq({tag, "_lo"}, lo, exp_lo);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 1'b0);
        check_eq({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int done_seen;
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        hiwe = 1'b0; lowe = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_hi", hi, 32'h0);
        check_eq("rst_lo", lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // MTHI/MTLO in idle.
        hiwe = 1'b1; lowe = 1'b0; wdata = 32'hA5A5_0001;
        @(negedge clk);
        hiwe = 1'b0; lowe = 1'b1; wdata = 32'h5A5A_0002;
        @(negedge clk);
        lowe = 1'b0;
        check_eq("mthi", hi, 32'hA5A5_0001);
        check_eq("mtlo", lo, 32'h5A5A_0002);

        run_op("mult_neg1x2", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("multu_ffx2",  2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("divu_100_7",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        run_op("divu_7_0",    2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_m7_0",    2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        run_op("mult_inject", 2'b00, 32'h0000_1234, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_C964, 1'b1, 1'b0);
        run_op("div_wr_drop", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 1'b1);

        // Abort a DIV with reset ten cycles in.
        start = 1'b1; op = 2'b10; srca = 32'd1000; srcb = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("pre_rst_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_hi", hi, 32'h0);
        check_eq("abort_lo", lo, 32'h0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 2) reset = 1'b0;
            if (done) done_seen++;
        end
        check_eq("abort_no_done", done_seen, 0);
        run_op("multu_3x4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO register width; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, meaning a request to begin an operation on srca/srcb/op.
REQ-005 SHALL have port op, input, 2, with encoding 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports srca and srcb, input, WIDTH each: srca is the multiplicand or dividend, srcb the multiplier or divisor.
REQ-007 SHALL have ports hiwe and lowe, input, 1 each, plus wdata, input, WIDTH, meaning the MTHI and MTLO writes.
REQ-008 SHALL have port busy, output, 1, meaning an operation is in progress.
REQ-009 SHALL have port done, output, 1, a single-cycle result-ready pulse.
REQ-010 SHALL have ports hi and lo, output, WIDTH each, driven directly from the HI/LO registers.

Function
REQ-011 SHALL implement the states IDLE, RUN and FIN.
REQ-012 In IDLE, start=1 SHALL latch the operand magnitudes, operand signs and op, clear the iteration counter, and move to RUN.
REQ-013 RUN SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle, for exactly WIDTH cycles, then move to FIN.
REQ-014 FIN SHALL apply the sign correction, write hi/lo, assert done for that one cycle, and return to IDLE.
REQ-015 Latency: if start is sampled at edge N, done SHALL be high in the cycle after edge N+WIDTH+1, and hi/lo SHALL hold the new result from that same edge.
REQ-016 busy SHALL be 1 whenever the state is RUN or FIN, and 0 in IDLE.
REQ-017 start while busy SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-018 Back-to-back: start is accepted in the cycle after done, since the state is IDLE again.
REQ-019 MULT/MULTU SHALL produce the 2*WIDTH-bit product, upper half to hi and lower half to lo; MULT treats operands as two's complement, MULTU as unsigned.
REQ-020 DIV/DIVU SHALL write the quotient to lo and the remainder to hi, using truncation toward zero; the remainder takes the sign of the dividend (DIV).
REQ-021 Divide by zero (DIV or DIVU) SHALL set lo to all ones and hi to srca, with the normal latency and done pulse.
REQ-022 Signed overflow, DIV of the most-negative value by -1, SHALL set lo to the most-negative value and hi to 0.
REQ-023 hiwe/lowe in IDLE SHALL load wdata into hi/lo at the next edge; while busy they SHALL be ignored.
REQ-024 start together with hiwe/lowe in IDLE: start SHALL take effect and the writes SHALL be dropped.
REQ-025 Operands and op SHALL be used only as sampled on the start edge; later changes to them have no effect.
REQ-026 hi/lo SHALL hold their values between operations; an operation is not visible in hi/lo until FIN.

Reset
REQ-027 On reset, state SHALL go to IDLE, and busy, done, hi, lo and all internal datapath registers SHALL go to 0, immediately and independent of clk.
REQ-028 Reset mid-operation SHALL abort it with no done pulse; the first start after reset release SHALL behave as from power-up.

Structure
REQ-029 The op encodings and the state enumeration SHALL live in the shared package muldiv_pkg; WIDTH stays a module parameter.
REQ-030 A single sub-module muldiv_negate (parametrised two's-complement conditional negate) SHALL be used for operand magnitude conversion and for result sign correction; everything else stays in one module.

Verification (WIDTH=32)
REQ-031 MULT with srca=0xFFFFFFFF, srcb=2 SHALL give hi=0xFFFFFFFF, lo=0xFFFFFFFE, with done exactly 33 cycles after start is sampled.
REQ-032 MULTU with the same operands SHALL give hi=0x00000001, lo=0xFFFFFFFE, and busy SHALL be high for 33 cycles.
REQ-033 DIV with -7/2 SHALL give lo=0xFFFFFFFD and hi=0xFFFFFFFF; back-to-back DIVU 100/7, started the cycle after done, SHALL give lo=14, hi=2.
REQ-034 DIVU 7/0 SHALL give lo=0xFFFFFFFF, hi=7; DIV 0x80000000/0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-035 A start pulse issued 5 cycles into a MULT SHALL be ignored, giving the first result only; hiwe with wdata=0x1234 while busy SHALL leave hi unchanged.
REQ-036 Asserting reset 10 cycles into a DIV SHALL make busy=0 and hi=lo=0 immediately, with no done pulse; a MULTU 3*4 issued afterwards SHALL give hi=0, lo=12.
